scroll_scheduler: RTL and testbench

Sequences the level scroll position (frame_counter) that drives the background, coin placement and the win check in the game-status FSM. It converts the ~60 Hz frame_clk into single-cycle ticks in the Clk domain and advances the scroll by a level-dependent speed only while the game is in PLAY. It also handles a player pause toggle and holds the scroll on WIN/LOSE. It sits between the keyboard/VGA front end and the game-status FSM and background blocks.

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_tick_gen.sv | 26 ++
 rtl/scroll_scheduler.sv | 123 ++++++++++++
 tb/tb_scroll_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level constants: status one-hot codes, level codes, keycodes
// and the scroll scheduler state encoding.
package game_pkg;

    localparam logic [4:0] ST_SELECT = 5'b10000;
    localparam logic [4:0] ST_WAIT   = 5'b01000;
    localparam logic [4:0] ST_PLAY   = 5'b00100;
    localparam logic [4:0] ST_WIN    = 5'b00010;
    localparam logic [4:0] ST_LOSE   = 5'b00001;

    localparam logic [1:0] LVL1 = 2'b01;
    localparam logic [1:0] LVL2 = 2'b10;

    localparam logic [7:0] KEY_SPACE = 8'h2c;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_P     = 8'h13;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FREEZE} sched_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the asynchronous frame strobe into one registered Clk-cycle tick per
// rising edge: 2-flop synchroniser, edge detect, output register.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync0, sync1, sync_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            sync_prev  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync0      <= frame_clk;
            sync1      <= sync0;
            sync_prev  <= sync1;
            frame_tick <= sync1 & ~sync_prev;
        end
    end

endmodule

// File: rtl/scroll_scheduler.sv
// Level scroll sequencer: advances frame_counter by a level-dependent speed on
// each frame tick while in PLAY, with pause toggle and WIN/LOSE hold.
// Optional SCROLL_ACCEL_EN adds distance-based speed-up capped at MAX_SPEED.
module scroll_scheduler
    import game_pkg::*;
#(
    parameter int         WIN_FRAME = 3000,
    parameter int         L1_SPEED  = 1,
    parameter int         L2_SPEED  = 2,
    parameter logic [7:0] PAUSE_KEY = KEY_P
`ifdef SCROLL_ACCEL_EN
    ,
    parameter int         ACCEL_STEP = 1024,
    parameter int         MAX_SPEED  = 6
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [4:0]  status,
    input  logic [1:0]  level_status,
    output logic [11:0] frame_counter,
    output logic [3:0]  scroll_speed,
    output logic        paused,
    output logic        frame_tick
);

    localparam logic [12:0] WIN13 = 13'(WIN_FRAME);
    localparam logic [3:0]  L1SP  = 4'(L1_SPEED);
    localparam logic [3:0]  L2SP  = 4'(L2_SPEED);

    sched_state_t state, state_n;
    logic [11:0]  cnt_n;
    logic [3:0]   spd_n;
    logic [7:0]   key_prev;
    logic         key_press;
    logic [3:0]   base;
    logic [3:0]   speed;
    logic [12:0]  sum;
    logic         go_freeze, go_idle, in_play;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign key_press = (keycode == PAUSE_KEY) && (key_prev != PAUSE_KEY);
    assign in_play   = (status == ST_PLAY);
    assign go_freeze = (status == ST_WIN)  || (status == ST_LOSE);
    assign go_idle   = (status == ST_WAIT) || (status == ST_SELECT);
    assign paused    = (state == PAUSE);

    always_comb begin
        base = 4'd0;
        if (level_status == LVL1)      base = L1SP;
        else if (level_status == LVL2) base = L2SP;
    end

`ifdef SCROLL_ACCEL_EN
    localparam int          SHIFT = $clog2(ACCEL_STEP);
    localparam logic [12:0] MAX13 = 13'(MAX_SPEED);
    logic [12:0] accel_sum;

    // Speed grows one step per ACCEL_STEP of scroll distance already covered.
    assign accel_sum = {9'd0, base} + 13'(frame_counter >> SHIFT);
    assign speed     = (accel_sum > MAX13) ? MAX13[3:0] : accel_sum[3:0];
`else
    assign speed = base;
`endif

    assign sum = {1'b0, frame_counter} + {9'd0, speed};

    // Status changes outrank the pause key, which outranks the frame tick.
    always_comb begin
        state_n = state;
        cnt_n   = frame_counter;
        spd_n   = scroll_speed;
        case (state)
            IDLE: begin
                cnt_n = '0;
                spd_n = '0;
                if (in_play) state_n = RUN;
            end
            RUN: begin
                if (go_freeze)      state_n = FREEZE;
                else if (go_idle)   state_n = IDLE;
                else if (key_press) state_n = PAUSE;
                else if (frame_tick && in_play) begin
                    cnt_n = (sum > WIN13) ? WIN13[11:0] : sum[11:0];
                    spd_n = speed;
                end
            end
            PAUSE: begin
                if (go_freeze)      state_n = FREEZE;
                else if (go_idle)   state_n = IDLE;
                else if (key_press) state_n = RUN;
            end
            FREEZE: begin
                if (go_idle)      state_n = IDLE;
                else if (in_play) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            frame_counter <= '0;
            scroll_speed  <= '0;
            key_prev      <= '0;
        end else begin
            state         <= state_n;
            frame_counter <= cnt_n;
            scroll_speed  <= spd_n;
            key_prev      <= keycode;
        end
    end

endmodule

// File: tb/tb_scroll_scheduler.sv
// Scoreboard bench for scroll_scheduler: expected counter/speed pushed per
// frame pulse, popped and compared once the DUT has consumed the tick.
module tb_scroll_scheduler;

    localparam logic [7:0] KP = 8'h13;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [4:0]  status = 5'b10000;
    logic [1:0]  level_status = 2'b01;
    logic [11:0] frame_counter;
    logic [3:0]  scroll_speed;
    logic        paused;
    logic        frame_tick;

    typedef struct {
        int cnt;
        int spd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    int   m_spd = 0;
    int   tick_cnt = 0;
    int   t0;

    scroll_scheduler dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .status        (status),
        .level_status  (level_status),
        .frame_counter (frame_counter),
        .scroll_speed  (scroll_speed),
        .paused        (paused),
        .frame_tick    (frame_tick)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_speed(input int cnt, input logic [1:0] lvl);
        int b;
        b = (lvl == 2'b01) ? 1 : (lvl == 2'b10) ? 2 : 0;
`ifdef SCROLL_ACCEL_EN
        b = b + cnt / 1024;
        if (b > 6) b = 6;
`endif
        return b;
    endfunction

    // One frame_clk pulse; adv says whether the scroll should move on this tick.
    task automatic frame_pulse(input bit adv, input bit key_at_tick);
        int   n;
        bit   seen;
        exp_t e;
        if (adv) begin
            m_spd = exp_speed(m_cnt, level_status);
            m_cnt = m_cnt + m_spd;
            if (m_cnt > 3000) m_cnt = 3000;
        end
        e.cnt = m_cnt;
        e.spd = m_spd;
        exp_q.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge Clk);
            n++;
            if (frame_tick) begin
                seen = 1'b1;
                if (key_at_tick) keycode = KP;
            end
        end
        chk("tick_latency", n, 3);
        @(negedge Clk);
        chk("tick_width", {31'd0, frame_tick}, 0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("frame_counter", {20'd0, frame_counter}, e.cnt);
            chk("scroll_speed", {28'd0, scroll_speed}, e.spd);
        end
        @(negedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic set_status(input logic [4:0] s);
        @(negedge Clk);
        status = s;
        repeat (3) @(negedge Clk);
        if (s == 5'b01000 || s == 5'b10000) begin
            m_cnt = 0;
            m_spd = 0;
        end
    endtask

    initial begin
        #5;
        chk("rst_counter", {20'd0, frame_counter}, 0);
        chk("rst_speed", {28'd0, scroll_speed}, 0);
        chk("rst_paused", {31'd0, paused}, 0);
        chk("rst_tick", {31'd0, frame_tick}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        set_status(5'b00100);

        // Level 1, ten frames
        t0 = tick_cnt;
        repeat (10) frame_pulse(1'b1, 1'b0);
        chk("l1_counter", {20'd0, frame_counter}, 10);
        chk("l1_speed", {28'd0, scroll_speed}, 1);
        chk("l1_ticks", tick_cnt - t0, 10);

        // Level 2 up to saturation
        level_status = 2'b10;
        while (m_cnt < 2998) frame_pulse(1'b1, 1'b0);
        frame_pulse(1'b1, 1'b0);
        chk("sat_reach", {20'd0, frame_counter}, 3000);
        repeat (5) frame_pulse(1'b1, 1'b0);
        chk("sat_hold", {20'd0, frame_counter}, 3000);
        set_status(5'b01000);
        chk("wait_clear", {20'd0, frame_counter}, 0);
        set_status(5'b00100);

        // Held pause key gives one press
        level_status = 2'b01;
        repeat (5) frame_pulse(1'b1, 1'b0);
        @(negedge Clk);
        keycode = KP;
        repeat (100) @(negedge Clk);
        chk("pause_on", {31'd0, paused}, 1);
        repeat (3) frame_pulse(1'b0, 1'b0);
        chk("pause_hold", {20'd0, frame_counter}, 5);
        keycode = 8'h00;
        repeat (3) @(negedge Clk);
        keycode = KP;
        repeat (3) @(negedge Clk);
        chk("pause_off", {31'd0, paused}, 0);
        keycode = 8'h00;
        frame_pulse(1'b1, 1'b0);
        chk("resume_adv", {20'd0, frame_counter}, 6);

        // Key press in the same cycle as the tick
        frame_pulse(1'b0, 1'b1);
        chk("keytick_pause", {31'd0, paused}, 1);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        keycode = KP;
        repeat (2) @(negedge Clk);
        keycode = 8'h00;
        chk("keytick_resume", {31'd0, paused}, 0);

        // Acceleration boundary at 1024
        set_status(5'b01000);
        set_status(5'b00100);
        while (m_cnt < 1023) frame_pulse(1'b1, 1'b0);
        frame_pulse(1'b1, 1'b0);
        chk("accel_1024", {20'd0, frame_counter}, 1024);
        frame_pulse(1'b1, 1'b0);
`ifdef SCROLL_ACCEL_EN
        chk("accel_next", {20'd0, frame_counter}, 1026);
        chk("accel_speed", {28'd0, scroll_speed}, 2);
`else
        chk("accel_next", {20'd0, frame_counter}, 1025);
        chk("accel_speed", {28'd0, scroll_speed}, 1);
`endif

        // LOSE hold, resume from held value, WAIT clear
        set_status(5'b01000);
        set_status(5'b00100);
        level_status = 2'b10;
        repeat (250) frame_pulse(1'b1, 1'b0);
        chk("at_500", {20'd0, frame_counter}, 500);
        set_status(5'b00001);
        repeat (3) frame_pulse(1'b0, 1'b0);
        chk("lose_hold", {20'd0, frame_counter}, 500);
        set_status(5'b00100);
        frame_pulse(1'b1, 1'b0);
        chk("freeze_resume", {20'd0, frame_counter}, 502);
        set_status(5'b01000);
        chk("wait_zero", {20'd0, frame_counter}, 0);
        chk("wait_speed", {28'd0, scroll_speed}, 0);

        // Asynchronous reset between clock edges
        set_status(5'b00100);
        repeat (2) frame_pulse(1'b1, 1'b0);
        chk("pre_reset", {20'd0, frame_counter}, 4);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_cnt", {20'd0, frame_counter}, 0);
        chk("async_rst_spd", {28'd0, scroll_speed}, 0);
        chk("async_rst_paused", {31'd0, paused}, 0);
        repeat (2) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
